// File: rtl/exception_unit.sv
// Machine-mode trap/CSR responder at WB: detects illegal/ecall/interrupt/mret/csr, updates M-mode CSRs.
// Flushes and cancel are combinational in the detect cycle; the PC redirect is registered and lasts one cycle.
module exception_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_WB,
    input  logic [1:0]  exp_vector_WB,
    input  logic        mret_WB,
    input  logic        csr_rw_WB,
    input  logic        csr_w_imm_mux_WB,
    input  logic [1:0]  csr_funct3_WB,
    input  logic [11:0] csr_addr_WB,
    input  logic [31:0] rs1_data_WB,
    input  logic [4:0]  zimm_WB,
    input  logic [31:0] inst_WB,
    input  logic [31:0] pc_WB,
    input  logic [31:0] pc_next_WB,
    input  logic        interrupt,
    output logic [31:0] csr_r_data,
    output logic        reg_FD_flush,
    output logic        reg_DE_flush,
    output logic        reg_EM_flush,
    output logic        reg_MW_flush,
    output logic        RegWrite_cancel,
    output logic        redirect_mux,
    output logic [31:0] PC_redirect
);
    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;

    typedef enum logic {IDLE = 1'b0, REDIRECT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] target_q, target_d;
    logic        mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
    logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d, mtval_q, mtval_d;

    logic        take, no_exp, irq_en;
    logic        take_ill, take_ecall, take_irq, take_mret, take_csr, take_trap;
    logic [31:0] csr_src, csr_wdata;
    logic        csr_we;

    // Priority chain: illegal > ecall > interrupt > mret > csr, only in IDLE on a real instruction.
    assign take       = (state_q == IDLE) && valid_WB;
    assign no_exp     = (exp_vector_WB == 2'b00);
    assign irq_en     = interrupt && mst_mie_q && mie_q[11];
    assign take_ill   = take && exp_vector_WB[1];
    assign take_ecall = take && !exp_vector_WB[1] && exp_vector_WB[0];
    assign take_irq   = take && no_exp && irq_en;
    assign take_mret  = take && no_exp && !irq_en && mret_WB;
    assign take_csr   = take && no_exp && !irq_en && !mret_WB && csr_rw_WB;
    assign take_trap  = take_ill || take_ecall || take_irq;

    always_comb begin
        csr_r_data = 32'h0;
        case (csr_addr_WB)
            A_MSTATUS: csr_r_data = {24'h0, mst_mpie_q, 3'b000, mst_mie_q, 3'b000};
            A_MIE:     csr_r_data = mie_q;
            A_MTVEC:   csr_r_data = mtvec_q;
            A_MEPC:    csr_r_data = mepc_q;
            A_MCAUSE:  csr_r_data = mcause_q;
            A_MTVAL:   csr_r_data = mtval_q;
            default:   csr_r_data = 32'h0;
        endcase
    end

    always_comb begin
        csr_src   = csr_w_imm_mux_WB ? {27'h0, zimm_WB} : rs1_data_WB;
        csr_wdata = csr_r_data;
        case (csr_funct3_WB)
            2'b01:   csr_wdata = csr_src;
            2'b10:   csr_wdata = csr_r_data | csr_src;
            2'b11:   csr_wdata = csr_r_data & ~csr_src;
            default: csr_wdata = csr_r_data;
        endcase
        csr_we = take_csr && (csr_funct3_WB != 2'b00);
    end

    // Next-state process
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (take_trap || take_mret) state_d = REDIRECT;
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // CSR and redirect-target datapath
    always_comb begin
        target_d   = target_q;
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        if (take_trap) begin
            mepc_d     = take_irq ? {pc_next_WB[31:2], 2'b00} : {pc_WB[31:2], 2'b00};
            mcause_d   = take_ill ? 32'd2 : (take_ecall ? 32'd11 : 32'h8000_000B);
            mtval_d    = take_ill ? inst_WB : 32'h0;
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
            target_d   = {mtvec_q[31:2], 2'b00};
        end else if (take_mret) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
            target_d   = mepc_q;
        end else if (csr_we) begin
            case (csr_addr_WB)
                A_MSTATUS: begin
                    mst_mie_d  = csr_wdata[3];
                    mst_mpie_d = csr_wdata[7];
                end
                A_MIE:    mie_d    = csr_wdata;
                A_MTVEC:  mtvec_d  = csr_wdata;
                A_MEPC:   mepc_d   = {csr_wdata[31:2], 2'b00};
                A_MCAUSE: mcause_d = csr_wdata;
                A_MTVAL:  mtval_d  = csr_wdata;
                default:  ;
            endcase
        end
    end

    // Output process
    always_comb begin
        redirect_mux    = (state_q == REDIRECT);
        PC_redirect     = redirect_mux ? target_q : 32'h0;
        reg_FD_flush    = redirect_mux || take_trap || take_mret;
        reg_DE_flush    = take_trap || take_mret;
        reg_EM_flush    = take_trap || take_mret;
        reg_MW_flush    = take_trap || take_mret;
        RegWrite_cancel = take_ill || take_ecall;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            target_q   <= 32'h0;
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mie_q      <= 32'h0;
            mtvec_q    <= MTVEC_RESET;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
            mtval_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
        end
    end
endmodule

// File: tb/tb_exception_unit.sv
// Bench for exception_unit: directed vector table for the trap/MRET/CSR scenarios, then random stimulus
// compared against a rule-level model of the M-mode CSR file.
module tb_exception_unit;
    localparam logic [31:0] MTVEC_RST = 32'h200;
    localparam logic [11:0] A_ST = 12'h300, A_IE = 12'h304, A_TV = 12'h305;
    localparam logic [11:0] A_EPC = 12'h341, A_CA = 12'h342, A_VAL = 12'h343, A_UNK = 12'h7C0;

    logic        clk = 1'b0;
    logic        rst, valid_WB, mret_WB, csr_rw_WB, csr_w_imm_mux_WB, interrupt;
    logic [1:0]  exp_vector_WB, csr_funct3_WB;
    logic [11:0] csr_addr_WB;
    logic [31:0] rs1_data_WB, inst_WB, pc_WB, pc_next_WB;
    logic [4:0]  zimm_WB;
    logic [31:0] csr_r_data, PC_redirect;
    logic        reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush, RegWrite_cancel, redirect_mux;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exception_unit #(.MTVEC_RESET(MTVEC_RST)) dut (
        .clk(clk), .rst(rst), .valid_WB(valid_WB), .exp_vector_WB(exp_vector_WB), .mret_WB(mret_WB),
        .csr_rw_WB(csr_rw_WB), .csr_w_imm_mux_WB(csr_w_imm_mux_WB), .csr_funct3_WB(csr_funct3_WB),
        .csr_addr_WB(csr_addr_WB), .rs1_data_WB(rs1_data_WB), .zimm_WB(zimm_WB), .inst_WB(inst_WB),
        .pc_WB(pc_WB), .pc_next_WB(pc_next_WB), .interrupt(interrupt), .csr_r_data(csr_r_data),
        .reg_FD_flush(reg_FD_flush), .reg_DE_flush(reg_DE_flush), .reg_EM_flush(reg_EM_flush),
        .reg_MW_flush(reg_MW_flush), .RegWrite_cancel(RegWrite_cancel), .redirect_mux(redirect_mux),
        .PC_redirect(PC_redirect)
    );

    typedef struct {
        string     nm;
        bit        rst, vld;
        bit [1:0]  ex;
        bit        mr, cs, im;
        bit [1:0]  f3;
        bit [11:0] ad;
        bit [31:0] rs1;
        bit [4:0]  zi;
        bit [31:0] ins, pc, pcn;
        bit        irq;
        bit [3:0]  fl;   // {FD, DE, EM, MW}
        bit        cn, rm;
        bit [31:0] pcr, rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string nm, bit r, bit vld, bit [1:0] ex, bit mr, bit cs, bit im,
                                bit [1:0] f3, bit [11:0] ad, bit [31:0] rs1, bit [4:0] zi,
                                bit [31:0] ins, bit [31:0] pc, bit [31:0] pcn, bit irq,
                                bit [3:0] fl, bit cn, bit rm, bit [31:0] pcr, bit [31:0] rd);
        vec_t v;
        v.nm = nm; v.rst = r; v.vld = vld; v.ex = ex; v.mr = mr; v.cs = cs; v.im = im; v.f3 = f3;
        v.ad = ad; v.rs1 = rs1; v.zi = zi; v.ins = ins; v.pc = pc; v.pcn = pcn; v.irq = irq;
        v.fl = fl; v.cn = cn; v.rm = rm; v.pcr = pcr; v.rd = rd;
        return v;
    endfunction

    // Reference model: architectural CSR contents plus a "redirect owed" flag.
    bit [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_mtval, m_target;
    bit        m_redir;

    function automatic bit [31:0] m_read(bit [11:0] a);
        case (a)
            A_ST:    return m_mstatus & 32'h88;
            A_IE:    return m_mie;
            A_TV:    return m_mtvec;
            A_EPC:   return m_mepc;
            A_CA:    return m_mcause;
            A_VAL:   return m_mtval;
            default: return 32'h0;
        endcase
    endfunction

    // 0 none, 1 illegal, 2 ecall, 3 interrupt, 4 mret, 5 csr
    function automatic int m_event(vec_t v);
        if (m_redir || !v.vld) return 0;
        if (v.ex[1]) return 1;
        if (v.ex[0]) return 2;
        if (v.irq && m_mstatus[3] && m_mie[11]) return 3;
        if (v.mr) return 4;
        if (v.cs) return 5;
        return 0;
    endfunction

    function automatic bit [69:0] m_expect(vec_t v);
        int e = m_event(v);
        bit [3:0] fl = (m_redir ? 4'b1000 : 4'b0000) | ((e >= 1 && e <= 4) ? 4'b1111 : 4'b0000);
        bit cn = (e == 1 || e == 2);
        return {fl, cn, m_redir, (m_redir ? m_target : 32'h0), m_read(v.ad)};
    endfunction

    task automatic m_commit(vec_t v);
        int e = m_event(v);
        bit [31:0] old, src, nv;
        if (v.rst) begin
            m_mstatus = 0; m_mie = 0; m_mtvec = MTVEC_RST; m_mepc = 0; m_mcause = 0; m_mtval = 0;
            m_target = 0; m_redir = 0;
            return;
        end
        if (m_redir) begin
            m_redir = 0;
            return;
        end
        if (e >= 1 && e <= 3) begin
            m_mepc    = ((e == 3) ? v.pcn : v.pc) & ~32'h3;
            m_mcause  = (e == 1) ? 32'd2 : (e == 2) ? 32'd11 : 32'h8000_000B;
            m_mtval   = (e == 1) ? v.ins : 32'h0;
            m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
            m_target  = m_mtvec & ~32'h3;
            m_redir   = 1;
        end else if (e == 4) begin
            m_mstatus = m_mstatus[7] ? 32'h88 : 32'h80;
            m_target  = m_mepc;
            m_redir   = 1;
        end else if (e == 5 && v.f3 != 0) begin
            old = m_read(v.ad);
            src = v.im ? 32'(v.zi) : v.rs1;
            nv  = (v.f3 == 1) ? src : (v.f3 == 2) ? (old | src) : (old & ~src);
            case (v.ad)
                A_ST:  m_mstatus = nv & 32'h88;
                A_IE:  m_mie     = nv;
                A_TV:  m_mtvec   = nv;
                A_EPC: m_mepc    = nv & ~32'h3;
                A_CA:  m_mcause  = nv;
                A_VAL: m_mtval   = nv;
                default: ;
            endcase
        end
    endtask

    task automatic drive(vec_t v);
        rst = v.rst; valid_WB = v.vld; exp_vector_WB = v.ex; mret_WB = v.mr; csr_rw_WB = v.cs;
        csr_w_imm_mux_WB = v.im; csr_funct3_WB = v.f3; csr_addr_WB = v.ad; rs1_data_WB = v.rs1;
        zimm_WB = v.zi; inst_WB = v.ins; pc_WB = v.pc; pc_next_WB = v.pcn; interrupt = v.irq;
    endtask

    function automatic bit [69:0] dut_out();
        return {reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush, RegWrite_cancel,
                redirect_mux, PC_redirect, csr_r_data};
    endfunction

    task automatic check(string nm, bit [69:0] got, bit [69:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got fl=%b cn=%b rm=%b pcr=%h rd=%h expected fl=%b cn=%b rm=%b pcr=%h rd=%h",
                     nm, got[69:66], got[65], got[64], got[63:32], got[31:0],
                     exp[69:66], exp[65], exp[64], exp[63:32], exp[31:0]);
        end
    endtask

    initial begin
        vec_t v;
        bit [11:0] addrs[7];
        addrs = '{A_ST, A_IE, A_TV, A_EPC, A_CA, A_VAL, A_UNK};

        //        name           rst vld ex    mr cs im f3 addr   rs1            zi     inst           pc       pcn      irq  fl    cn rm pcr       rd
        tbl.push_back(mk("rst_mtvec",    0,0,2'b00,0,0,0,0,A_TV, 0,             0,     0,             0,       0,       0,   4'h0,0,0,0,        MTVEC_RST));
        tbl.push_back(mk("rst_mstatus",  0,0,2'b00,0,0,0,0,A_ST, 0,             0,     0,             0,       0,       0,   4'h0,0,0,0,        0));
        tbl.push_back(mk("csrrw_mtvec",  0,1,2'b00,0,1,0,1,A_TV, 32'h100,       0,     0,             0,       0,       0,   4'h0,0,0,0,        MTVEC_RST));
        tbl.push_back(mk("ecall",        0,1,2'b01,0,0,0,0,A_TV, 0,             0,     32'h73,        32'h40,  32'h44,  0,   4'hF,1,0,0,        32'h100));
        tbl.push_back(mk("ecall_redir",  0,1,2'b10,0,0,0,0,A_EPC,0,             0,     0,             0,       0,       0,   4'h8,0,1,32'h100,  32'h40));
        tbl.push_back(mk("ecall_mcause", 0,0,2'b00,0,0,0,0,A_CA, 0,             0,     0,             0,       0,       0,   4'h0,0,0,0,        32'd11));
        tbl.push_back(mk("ecall_mtval",  0,0,2'b00,0,0,0,0,A_VAL,0,             0,     0,             0,       0,       0,   4'h0,0,0,0,        0));
        tbl.push_back(mk("illegal",      0,1,2'b10,0,0,0,0,A_TV, 0,             0,     32'hFFFFFFFF,  32'h80,  32'h84,  0,   4'hF,1,0,0,        32'h100));
        tbl.push_back(mk("ill_redir",    0,0,2'b00,0,0,0,0,A_VAL,0,             0,     0,             0,       0,       0,   4'h8,0,1,32'h100,  32'hFFFFFFFF));
        tbl.push_back(mk("ill_mcause",   0,0,2'b00,0,0,0,0,A_CA, 0,             0,     0,             0,       0,       0,   4'h0,0,0,0,        32'd2));
        tbl.push_back(mk("ill_mepc",     0,0,2'b00,0,0,0,0,A_EPC,0,             0,     0,             0,       0,       0,   4'h0,0,0,0,        32'h80));
        tbl.push_back(mk("mtvec_lowbits",0,1,2'b00,0,1,0,1,A_TV, 32'h103,       0,     0,             0,       0,       0,   4'h0,0,0,0,        32'h100));
        tbl.push_back(mk("set_mstatus",  0,1,2'b00,0,1,0,1,A_ST, 32'h8,         0,     0,             0,       0,       0,   4'h0,0,0,0,        0));
        tbl.push_back(mk("set_mie",      0,1,2'b00,0,1,0,2,A_IE, 32'h800,       0,     0,             0,       0,       0,   4'h0,0,0,0,        0));
        tbl.push_back(mk("irq",          0,1,2'b00,0,0,0,0,A_ST, 0,             0,     0,             32'h20,  32'h24,  1,   4'hF,0,0,0,        32'h8));
        tbl.push_back(mk("irq_redir",    0,1,2'b00,0,0,0,0,A_ST, 0,             0,     0,             0,       0,       1,   4'h8,0,1,32'h100,  32'h80));
        tbl.push_back(mk("irq_masked",   0,1,2'b00,0,0,0,0,A_EPC,0,             0,     0,             0,       0,       1,   4'h0,0,0,0,        32'h24));
        tbl.push_back(mk("irq_mcause",   0,0,2'b00,0,0,0,0,A_CA, 0,             0,     0,             0,       0,       0,   4'h0,0,0,0,        32'h8000000B));
        tbl.push_back(mk("mret",         0,1,2'b00,1,0,0,0,A_CA, 0,             0,     0,             0,       0,       0,   4'hF,0,0,0,        32'h8000000B));
        tbl.push_back(mk("mret_redir",   0,0,2'b00,0,0,0,0,A_ST, 0,             0,     0,             0,       0,       0,   4'h8,0,1,32'h24,   32'h88));
        tbl.push_back(mk("csrrw_mtval",  0,1,2'b00,0,1,0,1,A_VAL,32'h10,        0,     0,             0,       0,       0,   4'h0,0,0,0,        0));
        tbl.push_back(mk("csrrsi_mtval", 0,1,2'b00,0,1,1,2,A_VAL,32'hFFFF0000,  5'd5,  0,             0,       0,       0,   4'h0,0,0,0,        32'h10));
        tbl.push_back(mk("csrrc_mtval",  0,1,2'b00,0,1,0,3,A_VAL,32'h5,         5'd31, 0,             0,       0,       0,   4'h0,0,0,0,        32'h15));
        tbl.push_back(mk("mtval_after_c",0,0,2'b00,0,0,0,0,A_VAL,0,             0,     0,             0,       0,       0,   4'h0,0,0,0,        32'h10));
        tbl.push_back(mk("funct3_00",    0,1,2'b00,0,1,0,0,A_VAL,32'hFF,        0,     0,             0,       0,       0,   4'h0,0,0,0,        32'h10));
        tbl.push_back(mk("mtval_kept",   0,0,2'b00,0,0,0,0,A_VAL,0,             0,     0,             0,       0,       0,   4'h0,0,0,0,        32'h10));
        tbl.push_back(mk("unk_write",    0,1,2'b00,0,1,0,1,A_UNK,32'hABCD,      0,     0,             0,       0,       0,   4'h0,0,0,0,        0));
        tbl.push_back(mk("unk_read",     0,0,2'b00,0,0,0,0,A_UNK,0,             0,     0,             0,       0,       0,   4'h0,0,0,0,        0));
        tbl.push_back(mk("ill_plus_irq", 0,1,2'b10,0,0,0,0,A_CA, 0,             0,     32'hDEAD0000,  32'h90,  32'h94,  1,   4'hF,1,0,0,        32'h8000000B));
        tbl.push_back(mk("ill_irq_redir",0,1,2'b00,0,0,0,0,A_CA, 0,             0,     0,             0,       0,       1,   4'h8,0,1,32'h100,  32'd2));
        tbl.push_back(mk("irq_pending",  0,1,2'b00,0,0,0,0,A_ST, 0,             0,     0,             0,       0,       1,   4'h0,0,0,0,        32'h80));
        tbl.push_back(mk("mret_w_irq",   0,1,2'b00,1,0,0,0,A_ST, 0,             0,     0,             0,       0,       1,   4'hF,0,0,0,        32'h80));
        tbl.push_back(mk("mret_w_redir", 0,1,2'b00,0,0,0,0,A_ST, 0,             0,     0,             0,       0,       1,   4'h8,0,1,32'h90,   32'h88));
        tbl.push_back(mk("irq_reenabled",0,1,2'b00,0,0,0,0,A_CA, 0,             0,     0,             32'h98,  32'h9C,  1,   4'hF,0,0,0,        32'd2));
        tbl.push_back(mk("irq2_redir",   0,0,2'b00,0,0,0,0,A_CA, 0,             0,     0,             0,       0,       0,   4'h8,0,1,32'h100,  32'h8000000B));
        tbl.push_back(mk("irq2_mepc",    0,0,2'b00,0,0,0,0,A_EPC,0,             0,     0,             0,       0,       0,   4'h0,0,0,0,        32'h9C));
        tbl.push_back(mk("mie_on_again", 0,1,2'b00,0,1,0,1,A_ST, 32'h8,         0,     0,             0,       0,       0,   4'h0,0,0,0,        32'h80));
        tbl.push_back(mk("irq_novalid",  0,0,2'b00,0,0,0,0,A_ST, 0,             0,     0,             0,       0,       1,   4'h0,0,0,0,        32'h08));
        tbl.push_back(mk("ecall_pre_rst",0,1,2'b01,0,0,0,0,A_ST, 0,             0,     0,             32'h50,  32'h54,  0,   4'hF,1,0,0,        32'h08));
        tbl.push_back(mk("rst_in_redir", 1,1,2'b00,0,1,0,1,A_EPC,32'h1234,      0,     0,             0,       0,       0,   4'h8,0,1,32'h100,  32'h50));
        tbl.push_back(mk("post_rst_mepc",0,0,2'b00,0,0,0,0,A_EPC,0,             0,     0,             0,       0,       0,   4'h0,0,0,0,        0));
        tbl.push_back(mk("post_rst_tvec",0,0,2'b00,0,0,0,0,A_TV, 0,             0,     0,             0,       0,       0,   4'h0,0,0,0,        MTVEC_RST));
        tbl.push_back(mk("post_rst_stat",0,0,2'b00,0,0,0,0,A_ST, 0,             0,     0,             0,       0,       0,   4'h0,0,0,0,        0));
        tbl.push_back(mk("post_rst_caus",0,0,2'b00,0,0,0,0,A_CA, 0,             0,     0,             0,       0,       0,   4'h0,0,0,0,        0));
        tbl.push_back(mk("post_rst_tval",0,0,2'b00,0,0,0,0,A_VAL,0,             0,     0,             0,       0,       0,   4'h0,0,0,0,        0));
        tbl.push_back(mk("post_rst_mie", 0,0,2'b00,0,0,0,0,A_IE, 0,             0,     0,             0,       0,       0,   4'h0,0,0,0,        0));

        v = mk("init", 1,0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
        drive(v);
        repeat (2) @(posedge clk);
        m_commit(v);

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            drive(tbl[i]);
            @(negedge clk);
            check(tbl[i].nm, dut_out(), {tbl[i].fl, tbl[i].cn, tbl[i].rm, tbl[i].pcr, tbl[i].rd});
            check({tbl[i].nm, "_model"}, dut_out(), m_expect(tbl[i]));
            m_commit(tbl[i]);
        end

        for (int n = 0; n < 600; n++) begin
            v.nm  = "random";
            v.rst = ($urandom_range(0, 49) == 0);
            v.vld = ($urandom_range(0, 3) != 0);
            v.ex  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            v.mr  = ($urandom_range(0, 7) == 0);
            v.cs  = ($urandom_range(0, 1) == 1);
            v.im  = $urandom_range(0, 1);
            v.f3  = 2'($urandom_range(0, 3));
            v.ad  = addrs[$urandom_range(0, 6)];
            v.rs1 = ($urandom_range(0, 2) == 0) ? 32'h888 : $urandom;
            v.zi  = 5'($urandom);
            v.ins = $urandom;
            v.pc  = $urandom & ~32'h3;
            v.pcn = v.pc + 32'd4;
            v.irq = ($urandom_range(0, 2) == 0);
            @(posedge clk);
            #1;
            drive(v);
            @(negedge clk);
            check("random", dut_out(), m_expect(v));
            m_commit(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
